gate_bist_sequencer: RTL and testbench

// - Built-in self-test sequencer for a small combinational gate network (and_gate -> not_gate NAND chain).
// - Walks every input vector, waits a settle interval, samples the result and checks it against a truth table.
// - Reports pass/fail, error count and first failing vector.
// - Replaces the hand-stepped stimulus with a synthesizable, start/done-controlled sequence.

---
 rtl/gate_bist_pkg.sv | 16 +
 rtl/gate_bist_settle_timer.sv | 40 ++++
 rtl/gate_bist_sequencer.sv | 115 +++++++++++
 tb/tb_gate_bist_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and truth-table constants for the gate-network BIST sequencer.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } bist_state_t;

    // Expected result per input vector, bit i = output for vector i.
    localparam logic [3:0] NAND_TRUTH = 4'b0111;
    localparam logic [3:0] AND_TRUTH  = 4'b1000;

endpackage

// File: rtl/gate_bist_settle_timer.sv
// Loadable down-counter with a zero flag; counts the settle interval after a
// vector is driven. With SETTLE_CYCLES=0 it degenerates to a constant flag.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    generate
        if (SETTLE_CYCLES == 0) begin : g_wire
            assign zero = 1'b1;
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, load, en};
        end else begin : g_cnt
            localparam int unsigned W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
            // Loading S-1 makes zero assert on the S-th enabled cycle.
            localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

            logic [W-1:0] cnt;

            // Reload on DRIVE, count down while settling, hold at zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (load) begin
                    cnt <= LOAD_VAL;
                end else if (en && (cnt != '0)) begin
                    cnt <= cnt - W'(1);
                end
            end

            assign zero = (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/gate_bist_sequencer.sv
// BIST sequencer: walks every input vector of a small combinational gate
// network, waits a settle interval, samples the result and compares it with
// a truth table. Reports pass/fail, error count and first failing vector.
module gate_bist_sequencer
    import gate_bist_pkg::*;
#(
    parameter int unsigned          N_IN          = 2,
    parameter logic [2**N_IN-1:0]   TRUTH         = (2**N_IN)'(NAND_TRUTH),
    parameter int unsigned          SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] dut_vec,
    input  logic            dut_r,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    bist_state_t     state;
    logic [N_IN-1:0] vec;
    logic            timer_zero;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == DRIVE),
        .en    (state == SETTLE),
        .zero  (timer_zero)
    );

    assign mismatch = (dut_r != TRUTH[vec]);
    assign err_next = err_count + (N_IN+1)'(mismatch);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            dut_vec          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else if (abort && (state != IDLE) && (state != DONE)) begin
            // Abort cancels the run but leaves the partial error record.
            state   <= IDLE;
            busy    <= 1'b0;
            dut_vec <= '0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state            <= DRIVE;
                        busy             <= 1'b1;
                        vec              <= '0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                DRIVE: begin
                    dut_vec <= vec;
                    state   <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vec;
                    end
                    if (vec == LAST_VEC) begin
                        // Pass is resolved here so it includes the final sample
                        // and is already valid while done is high.
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        vec   <= vec + N_IN'(1);
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Self-checking bench: three sequencers (SETTLE_CYCLES = 1, 0, 3) each drive a
// NAND gate model with an injectable per-vector fault mask. A position-based
// reference model predicts every output each cycle; directed runs pin the model
// with hand-computed literals.
module tb_gate_bist_sequencer;

    localparam logic [3:0] SPEC_TRUTH = 4'b0111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] mask = 4'b0000;

    logic [1:0] dut_vec_w [3];
    logic       dut_r_w   [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       pass_w    [3];
    logic [2:0] err_w     [3];
    logic       ffv_w     [3];
    logic [1:0] ffvec_w   [3];

    int n_cmp = 0;
    int n_bad = 0;
    int dcyc [3];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Gate output the fault-injected network produces for vector i.
    function automatic bit gate_r(input int i);
        bit a, b;
        a = bit'((i >> 1) & 1);
        b = bit'(i & 1);
        return (~(a & b)) ^ mask[i];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned S    = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int          P    = S + 2;
        localparam int          LAST = 4 * P;

        assign dut_r_w[g] = (~(dut_vec_w[g][1] & dut_vec_w[g][0])) ^ mask[dut_vec_w[g]];

        gate_bist_sequencer #(
            .N_IN          (2),
            .TRUTH         (4'b0111),
            .SETTLE_CYCLES (S)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .start            (start),
            .abort            (abort),
            .dut_vec          (dut_vec_w[g]),
            .dut_r            (dut_r_w[g]),
            .busy             (busy_w[g]),
            .done             (done_w[g]),
            .pass             (pass_w[g]),
            .err_count        (err_w[g]),
            .first_fail_valid (ffv_w[g]),
            .first_fail_vec   (ffvec_w[g])
        );

        // Model: p = edges since the accepting edge; vector p/P, phase p%P.
        bit m_act, m_ffv, m_pass;
        int m_p, m_errs, m_ffvec, m_dvec, m_i, m_ph;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_act = 0; m_p = 0; m_errs = 0; m_ffv = 0;
                m_ffvec = 0; m_dvec = 0; m_pass = 0;
            end else if (!m_act) begin
                if (start && !abort) begin
                    m_act = 1; m_p = 0; m_errs = 0; m_ffv = 0;
                    m_ffvec = 0; m_pass = 0;
                end
            end else if (m_p == LAST) begin
                m_act = 0;
            end else if (abort) begin
                m_act = 0; m_dvec = 0; m_pass = 0;
            end else begin
                m_i  = m_p / P;
                m_ph = m_p % P;
                if (m_ph == 0) m_dvec = m_i;
                if (m_ph == P - 1) begin
                    if (gate_r(m_i) != SPEC_TRUTH[m_i]) begin
                        m_errs++;
                        if (!m_ffv) begin
                            m_ffv   = 1;
                            m_ffvec = m_i;
                        end
                    end
                    if (m_i == 3) m_pass = (m_errs == 0);
                end
                m_p++;
            end
        end

        // Compare every output against the model once per cycle.
        always @(negedge clk) begin
            chk($sformatf("busy%0d", g),    busy_w[g],    m_act);
            chk($sformatf("done%0d", g),    done_w[g],    (m_act && m_p == LAST));
            chk($sformatf("pass%0d", g),    pass_w[g],    m_pass);
            chk($sformatf("err%0d", g),     err_w[g],     m_errs);
            chk($sformatf("ffv%0d", g),     ffv_w[g],     m_ffv);
            chk($sformatf("ffvec%0d", g),   ffvec_w[g],   m_ffvec);
            chk($sformatf("dut_vec%0d", g), dut_vec_w[g], m_dvec);
        end
    end

    // Pulse start, then watch up to 40 edges recording when each done fires.
    // restart_at > 0 re-pulses start at that cycle while the run is busy.
    task automatic run_measure(input int restart_at);
        int vec_tab [4];
        vec_tab = '{0, 1, 2, 3};
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        dcyc = '{0, 0, 0};
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++)
                if (done_w[g] && dcyc[g] == 0) dcyc[g] = c;
            if (c == 1 || c == 4 || c == 7 || c == 10)
                chk("walk_vec", dut_vec_w[0], vec_tab[(c - 1) / 3]);
            start = (c == restart_at);
        end
        start = 1'b0;
        chk("len_s1", dcyc[0], 12);
        chk("len_s0", dcyc[1], 8);
        chk("len_s3", dcyc[2], 20);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", done_w[0], 0);
        chk("rst_pass", pass_w[0], 0);
        chk("rst_err",  err_w[0], 0);
        chk("rst_vec",  dut_vec_w[0], 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;

        // Healthy NAND network.
        mask = 4'b0000;
        run_measure(0);
        chk("ok_pass", pass_w[0], 1);
        chk("ok_err",  err_w[0], 0);
        chk("ok_ffv",  ffv_w[0], 0);

        // Output forced to 1 at vector 3.
        mask = 4'b1000;
        run_measure(0);
        chk("f3_pass",  pass_w[0], 0);
        chk("f3_err",   err_w[0], 1);
        chk("f3_ffvec", ffvec_w[0], 3);
        chk("f3_ffv",   ffv_w[0], 1);

        // Output stuck at 0.
        mask = 4'b0111;
        run_measure(0);
        chk("sa0_pass",  pass_w[0], 0);
        chk("sa0_err",   err_w[2], 3);
        chk("sa0_ffvec", ffvec_w[0], 0);

        // Start while busy must not restart the run.
        mask = 4'b0000;
        run_measure(3);
        chk("rb_pass", pass_w[0], 1);

        // Abort in SETTLE of vector 2 (p = 7 for SETTLE_CYCLES=1).
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("ab_busy", busy_w[0], 0);
        chk("ab_done", done_w[0], 0);
        chk("ab_vec",  dut_vec_w[0], 0);
        chk("ab_pass", pass_w[0], 0);
        repeat (3) @(posedge clk);
        #2;
        run_measure(0);
        chk("ab_rerun_pass", pass_w[0], 1);

        // Start and abort together in IDLE: stays idle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy_w[0], 0);

        // Asynchronous reset mid-run with a non-zero error count.
        mask = 4'b0111;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy_w[0], 0);
        chk("ar_err",  err_w[0], 0);
        chk("ar_vec",  dut_vec_w[0], 0);
        chk("ar_ffv",  ffv_w[0], 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomised start/abort/fault traffic checked by the model.
        repeat (3000) begin
            @(posedge clk); #2;
            start = ($urandom % 6) == 0;
            abort = ($urandom % 30) == 0;
            if (($urandom % 10) == 0) mask = 4'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (25) @(posedge clk);
        #6;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
